igr_wadj_flow_ctrl: RTL and testbench

- Ingress admission and flow controller for the packet-switch width adjuster. Sits between the width-adjusted ingress stream and the ingress packet FIFO.
- Consumes the FIFO fill level and the CSR fields `cfg_rx_pause_en`, `rx_pause_threshold` and `drop_threshold`.
- Generates a hysteretic RX pause request to the MAC.
- Makes a per-packet drop/pass decision at SOP. A dropped packet is discarded whole.
- Keeps saturating statistics counters.

---
 rtl/igr_wadj_pkg.sv | 29 ++
 rtl/igr_wadj_sat_cnt.sv | 27 ++
 rtl/igr_wadj_flow_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_igr_wadj_flow_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/igr_wadj_pkg.sv
// Shared types and constants for the ingress width-adjuster flow controller.
package igr_wadj_pkg;

  // Width of the saturating statistics counters.
  localparam int unsigned CNT_W = 32;

  // CSR reset defaults for the pause and drop thresholds (in FIFO words).
  localparam logic [15:0] PAUSE_THR_DEF = 16'h0800;
  localparam logic [15:0] DROP_THR_DEF  = 16'h0FC0;

  // Per-packet admission state.
  typedef enum logic [1:0] {
    PKT_IDLE = 2'd0,
    PKT_PASS = 2'd1,
    PKT_DROP = 2'd2
  } pkt_state_e;

  // MAC pause state.
  typedef enum logic {
    PAUSE_XON  = 1'b0,
    PAUSE_XOFF = 1'b1
  } pause_state_e;

  // Unsigned a - b, clamped at zero instead of wrapping.
  function automatic logic [15:0] sat_sub16(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : 16'h0000;
  endfunction

endpackage

// File: rtl/igr_wadj_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module igr_wadj_sat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count up, hold at all-ones, clear on request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/igr_wadj_flow_ctrl.sv
// Ingress admission and flow control between the width-adjusted stream and
// the ingress packet FIFO: per-packet drop decision at SOP, hysteretic MAC
// pause request, and saturating statistics.
module igr_wadj_flow_ctrl
  import igr_wadj_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned LVL_W    = 16,
  parameter int unsigned HYST     = 64,
  parameter int unsigned MIN_HOLD = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_rx_pause_en,
  input  logic [15:0]       cfg_rx_pause_threshold,
  input  logic [15:0]       cfg_drop_threshold,
  input  logic [LVL_W-1:0]  fifo_level,
  input  logic              fifo_afull,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_wr_sop,
  output logic              fifo_wr_eop,
  output logic              rx_pause_req,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  drop_pkt_cnt,
  output logic [CNT_W-1:0]  pause_evt_cnt,
  output logic              err_sop_in_pkt
);

  localparam int unsigned       HOLD_W   = $clog2(MIN_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_REL = HOLD_W'(MIN_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = {HOLD_W{1'b1}};
  localparam logic [15:0]       HYST_LV  = 16'(HYST);

  pkt_state_e        pkt_q;
  pause_state_e      pause_q;
  logic [HOLD_W-1:0] hold_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_sop_q;
  logic              wr_eop_q;
  logic              pause_req_q;
  logic              err_q;

  logic [15:0] level_c;
  logic [15:0] release_thr_c;
  logic        accept_c;
  logic        sop_acc_c;
  logic        beat_acc_c;
  logic        drop_dec_c;
  logic        wr_c;
  logic        err_set_c;
  logic        drop_inc_c;
  logic        pause_on_c;
  logic        pause_off_c;

  // Level is compared as an unsigned 16-bit quantity.
  assign level_c       = 16'(fifo_level);
  assign release_thr_c = sat_sub16(cfg_rx_pause_threshold, HYST_LV);

  // A packet being dropped is drained unconditionally so it never stalls ingress.
  assign in_ready   = (pkt_q == PKT_DROP) ? 1'b1 : !fifo_afull;
  assign accept_c   = in_valid && in_ready;
  assign sop_acc_c  = accept_c && in_sop;
  assign beat_acc_c = accept_c && !in_sop;

  // Admission decision, only meaningful on an accepted SOP beat.
  assign drop_dec_c = (level_c >= cfg_drop_threshold);
  assign drop_inc_c = sop_acc_c && drop_dec_c;

  assign wr_c = (sop_acc_c && !drop_dec_c) ||
                (beat_acc_c && (pkt_q == PKT_PASS));

  // Protocol error: SOP inside an open packet, or a body beat with no packet open.
  assign err_set_c = (sop_acc_c && (pkt_q != PKT_IDLE)) ||
                     (beat_acc_c && (pkt_q == PKT_IDLE));

  assign pause_on_c  = (pause_q == PAUSE_XON) && cfg_rx_pause_en &&
                       (level_c >= cfg_rx_pause_threshold);
  assign pause_off_c = !cfg_rx_pause_en ||
                       ((level_c < release_thr_c) && (hold_q >= HOLD_REL));

  // Packet FSM: a new SOP always restarts the decision, abandoning any open packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q <= PKT_IDLE;
    end else if (sop_acc_c) begin
      if (in_eop) begin
        pkt_q <= PKT_IDLE;
      end else if (drop_dec_c) begin
        pkt_q <= PKT_DROP;
      end else begin
        pkt_q <= PKT_PASS;
      end
    end else if (beat_acc_c && in_eop) begin
      pkt_q <= PKT_IDLE;
    end
  end

  // One-cycle registered write path into the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_sop_q  <= 1'b0;
      wr_eop_q  <= 1'b0;
    end else begin
      wr_en_q  <= wr_c;
      wr_sop_q <= wr_c && in_sop;
      wr_eop_q <= wr_c && in_eop;
      if (wr_c) begin
        wr_data_q <= in_data;
      end
    end
  end

  // Sticky protocol-error flag, cleared together with the statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (stat_clr) begin
      err_q <= 1'b0;
    end else if (err_set_c) begin
      err_q <= 1'b1;
    end
  end

  // Pause FSM with minimum hold time and release hysteresis.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pause_q     <= PAUSE_XON;
      hold_q      <= '0;
      pause_req_q <= 1'b0;
    end else begin
      case (pause_q)
        PAUSE_XON: begin
          if (pause_on_c) begin
            pause_q     <= PAUSE_XOFF;
            hold_q      <= '0;
            pause_req_q <= 1'b1;
          end
        end
        PAUSE_XOFF: begin
          if (pause_off_c) begin
            pause_q     <= PAUSE_XON;
            pause_req_q <= 1'b0;
          end else if (hold_q != HOLD_MAX) begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          pause_q     <= PAUSE_XON;
          pause_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Dropped-packet statistics.
  igr_wadj_sat_cnt #(
    .W (CNT_W)
  ) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (stat_clr),
    .inc_i   (drop_inc_c),
    .cnt_o   (drop_pkt_cnt)
  );

  // XON to XOFF transition statistics.
  igr_wadj_sat_cnt #(
    .W (CNT_W)
  ) u_pause_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (stat_clr),
    .inc_i   (pause_on_c),
    .cnt_o   (pause_evt_cnt)
  );

  assign fifo_wr_en     = wr_en_q;
  assign fifo_wr_data   = wr_data_q;
  assign fifo_wr_sop    = wr_sop_q;
  assign fifo_wr_eop    = wr_eop_q;
  assign rx_pause_req   = pause_req_q;
  assign err_sop_in_pkt = err_q;

endmodule

// File: tb/tb_igr_wadj_flow_ctrl.sv
// Bench for igr_wadj_flow_ctrl: directed scenarios plus randomized traffic,
// each cycle compared against a behavioural model of the admission rules.
module tb_igr_wadj_flow_ctrl;
  import igr_wadj_pkg::*;

  localparam int DATA_W   = 64;
  localparam int LVL_W    = 16;
  localparam int HYST     = 64;
  localparam int MIN_HOLD = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_rx_pause_en;
  logic [15:0]       cfg_rx_pause_threshold;
  logic [15:0]       cfg_drop_threshold;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_afull;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              fifo_wr_sop;
  logic              fifo_wr_eop;
  logic              rx_pause_req;
  logic              stat_clr;
  logic [31:0]       drop_pkt_cnt;
  logic [31:0]       pause_evt_cnt;
  logic              err_sop_in_pkt;

  int tests;
  int fails;

  // Reference model state
  bit          m_open;
  bit          m_drop;
  bit          m_paused;
  int          m_held;
  longint      m_drops;
  longint      m_evts;
  bit          m_err;
  bit          m_wr;
  logic [63:0] m_wr_data;
  bit          m_wr_sop;
  bit          m_wr_eop;

  igr_wadj_flow_ctrl #(
    .DATA_W   (DATA_W),
    .LVL_W    (LVL_W),
    .HYST     (HYST),
    .MIN_HOLD (MIN_HOLD)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .cfg_rx_pause_en        (cfg_rx_pause_en),
    .cfg_rx_pause_threshold (cfg_rx_pause_threshold),
    .cfg_drop_threshold     (cfg_drop_threshold),
    .fifo_level             (fifo_level),
    .fifo_afull             (fifo_afull),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .in_data                (in_data),
    .in_sop                 (in_sop),
    .in_eop                 (in_eop),
    .fifo_wr_en             (fifo_wr_en),
    .fifo_wr_data           (fifo_wr_data),
    .fifo_wr_sop            (fifo_wr_sop),
    .fifo_wr_eop            (fifo_wr_eop),
    .rx_pause_req           (rx_pause_req),
    .stat_clr               (stat_clr),
    .drop_pkt_cnt           (drop_pkt_cnt),
    .pause_evt_cnt          (pause_evt_cnt),
    .err_sop_in_pkt         (err_sop_in_pkt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_drop = 0; m_paused = 0; m_held = 0;
    m_drops = 0; m_evts = 0; m_err = 0;
    m_wr = 0; m_wr_sop = 0; m_wr_eop = 0; m_wr_data = '0;
  endtask

  // Apply the admission, write and pause rules for one clock edge.
  task automatic model_step();
    bit rdy, acc, dropped;
    int lvl, thr, rel;
    lvl = int'(fifo_level);
    rdy = (m_open && m_drop) || !fifo_afull;
    acc = in_valid && rdy;
    m_wr = 0;
    if (acc) begin
      if (in_sop) begin
        if (m_open) m_err = 1;
        dropped = (lvl >= int'(cfg_drop_threshold));
        if (dropped) begin
          if (m_drops < 64'hFFFF_FFFF) m_drops++;
        end else begin
          m_wr = 1; m_wr_data = in_data; m_wr_sop = 1; m_wr_eop = in_eop;
        end
        m_open = !in_eop;
        m_drop = dropped;
      end else if (!m_open) begin
        m_err = 1;
      end else begin
        if (!m_drop) begin
          m_wr = 1; m_wr_data = in_data; m_wr_sop = 0; m_wr_eop = in_eop;
        end
        if (in_eop) m_open = 0;
      end
    end
    thr = int'(cfg_rx_pause_threshold);
    rel = (thr > HYST) ? thr - HYST : 0;
    if (!m_paused) begin
      if (cfg_rx_pause_en && lvl >= thr) begin
        m_paused = 1; m_held = 0;
        if (m_evts < 64'hFFFF_FFFF) m_evts++;
      end
    end else if (!cfg_rx_pause_en) begin
      m_paused = 0;
    end else if (lvl < rel && m_held >= MIN_HOLD - 1) begin
      m_paused = 0;
    end else begin
      m_held++;
    end
    if (stat_clr) begin
      m_drops = 0; m_evts = 0; m_err = 0;
    end
  endtask

  task automatic check_outputs();
    chk("fifo_wr_en", 64'(fifo_wr_en), 64'(m_wr));
    if (m_wr) begin
      chk("fifo_wr_data", fifo_wr_data, m_wr_data);
      chk("fifo_wr_sop", 64'(fifo_wr_sop), 64'(m_wr_sop));
      chk("fifo_wr_eop", 64'(fifo_wr_eop), 64'(m_wr_eop));
    end
    chk("rx_pause_req", 64'(rx_pause_req), 64'(m_paused));
    chk("drop_pkt_cnt", 64'(drop_pkt_cnt), 64'(m_drops));
    chk("pause_evt_cnt", 64'(pause_evt_cnt), 64'(m_evts));
    chk("err_sop_in_pkt", 64'(err_sop_in_pkt), 64'(m_err));
  endtask

  // Called at a falling edge with inputs already set.
  task automatic tick();
    bit exp_rdy;
    #1;
    exp_rdy = (m_open && m_drop) || !fifo_afull;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic beat(input bit s, input bit e);
    in_valid = 1; in_sop = s; in_eop = e;
    in_data = {$urandom, $urandom};
    tick();
    in_valid = 0; in_sop = 0; in_eop = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 0; in_sop = 0; in_eop = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_pulse();
    stat_clr = 1; tick(); stat_clr = 0;
  endtask

  // Asynchronous reset assertion, released at a falling edge.
  task automatic do_reset();
    reset_n = 0;
    #1;
    chk("rst_fifo_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_fifo_wr_sop", 64'(fifo_wr_sop), 64'd0);
    chk("rst_fifo_wr_eop", 64'(fifo_wr_eop), 64'd0);
    chk("rst_fifo_wr_data", fifo_wr_data, 64'd0);
    chk("rst_rx_pause_req", 64'(rx_pause_req), 64'd0);
    chk("rst_drop_pkt_cnt", 64'(drop_pkt_cnt), 64'd0);
    chk("rst_pause_evt_cnt", 64'(pause_evt_cnt), 64'd0);
    chk("rst_err_sop_in_pkt", 64'(err_sop_in_pkt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'(!fifo_afull));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    tests = 0; fails = 0;
    cfg_rx_pause_en = 1;
    cfg_rx_pause_threshold = PAUSE_THR_DEF;
    cfg_drop_threshold = DROP_THR_DEF;
    fifo_level = '0; fifo_afull = 0;
    in_valid = 0; in_data = '0; in_sop = 0; in_eop = 0;
    stat_clr = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();
    idle(2);

    // Pass-through of a 4-beat packet
    fifo_level = 16'h0100;
    beat(1, 0); beat(0, 0); beat(0, 0); beat(0, 1);
    idle(2);

    // Dropped 5-beat packet drained under backpressure; level falls mid-packet
    fifo_level = 16'h0FC0;
    beat(1, 0);
    fifo_afull = 1;
    beat(0, 0);
    fifo_level = 16'h0000;
    beat(0, 0); beat(0, 0); beat(0, 1);
    fifo_afull = 0;
    idle(40);
    clr_pulse();

    // Pause assert, hysteresis hold, release after minimum hold
    fifo_level = 16'h0100; idle(2);
    fifo_level = 16'h0800; idle(1);
    fifo_level = 16'h07D0; idle(40);
    fifo_level = 16'h07BF; idle(3);
    // Release requested early in the hold period
    fifo_level = 16'h0800; idle(1);
    fifo_level = 16'h07D0; idle(9);
    fifo_level = 16'h07BF; idle(30);

    // Enable off overrides the hold; disabled pause never asserts
    fifo_level = 16'h0900; idle(3);
    cfg_rx_pause_en = 0; idle(2);
    fifo_level = 16'hFFFF; idle(10);
    fifo_level = 16'h0000; idle(1);
    cfg_rx_pause_en = 1; idle(2);

    // Protocol error: SOP inside an open packet, second packet written
    fifo_level = 16'h0100;
    beat(1, 0); beat(0, 0); beat(1, 0); beat(0, 0); beat(0, 1);
    idle(2);
    // stat_clr coincident with a dropped single-beat packet
    fifo_level = 16'h0FC0;
    stat_clr = 1; beat(1, 1); stat_clr = 0;
    fifo_level = 16'h0000;
    idle(40);
    // Drop threshold of zero drops everything
    cfg_drop_threshold = 16'h0000;
    beat(1, 0); beat(0, 1); beat(1, 1);
    cfg_drop_threshold = DROP_THR_DEF;
    // Body beat with no open packet
    beat(0, 0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0)
        cfg_drop_threshold = ($urandom_range(0, 5) == 0) ? 16'h0000
                             : 16'($urandom_range(16'h0400, 16'h0C00));
      if ($urandom_range(0, 29) == 0)
        cfg_rx_pause_threshold = 16'($urandom_range(16'h0020, 16'h0900));
      if ($urandom_range(0, 39) == 0)
        cfg_rx_pause_en = !cfg_rx_pause_en;
      if ($urandom_range(0, 3) == 0)
        fifo_level = 16'($urandom_range(0, 16'h0E00));
      fifo_afull = ($urandom_range(0, 3) == 0);
      stat_clr = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_sop = ($urandom_range(0, 4) == 0);
      in_eop = ($urandom_range(0, 3) == 0);
      in_data = {$urandom, $urandom};
      tick();
    end
    stat_clr = 0; fifo_afull = 0; cfg_rx_pause_en = 1;
    cfg_rx_pause_threshold = PAUSE_THR_DEF;
    cfg_drop_threshold = DROP_THR_DEF;
    idle(2);

    // Reset while a dropped packet is open
    fifo_level = 16'h0FC0;
    beat(1, 0);
    fifo_afull = 1;
    beat(0, 0);
    do_reset();
    fifo_afull = 0;
    fifo_level = 16'h0100;
    beat(0, 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
